axil_ram_slave: RTL and testbench

AXIL_RAM_SLAVE -- requirements
Module: axil_ram_slave

---
 rtl/axil_ram_slave.sv | 214 +++++++++++++++++++++
 tb/tb_axil_ram_slave.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_ram_slave.sv
// AXI-Lite RAM target: DEPTH words of DATA_WIDTH bits, byte-strobed writes,
// independent write and read state machines, SLVERR outside the mapped window.
module axil_ram_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // write address channel
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  // write response channel
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  // read data channel
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int                  ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int                  IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH+1)'(DEPTH * STRB_WIDTH);
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_RESP} rstate_t;

  // Extra top bit catches addresses below BASE_ADDR (borrow out of the subtract).
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (off[ADDR_WIDTH] == 1'b0) && (off < SPAN);
  endfunction

  // Word index; byte-offset bits inside the word are dropped.
  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> ADDR_LSB);
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  wstate_t               r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;

  rstate_t               r_rstate;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_commit_addr;
  logic [DATA_WIDTH-1:0] w_commit_data;
  logic [STRB_WIDTH-1:0] w_commit_strb;
  logic                  w_commit_ok;
  logic [IDX_W-1:0]      w_commit_idx;
  logic                  w_ar_ok;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_unused_prot;

  assign w_unused_prot = ^{s_axil_awprot, s_axil_arprot};

  // Handshakes only count on registered readies, so valid never waits on ready combinationally.
  assign w_aw_hs = s_axil_awvalid & r_awready;
  assign w_w_hs  = s_axil_wvalid  & r_wready;
  assign w_ar_hs = s_axil_arvalid & r_arready;

  // A write completes when the missing half of the AW/W pair arrives (or both together).
  assign w_commit = ((r_wstate == W_IDLE)      & w_aw_hs & w_w_hs) |
                    ((r_wstate == W_ADDR_HELD) & w_w_hs) |
                    ((r_wstate == W_DATA_HELD) & w_aw_hs);

  assign w_commit_addr = (r_wstate == W_ADDR_HELD) ? r_awaddr : s_axil_awaddr;
  assign w_commit_data = (r_wstate == W_DATA_HELD) ? r_wdata  : s_axil_wdata;
  assign w_commit_strb = (r_wstate == W_DATA_HELD) ? r_wstrb  : s_axil_wstrb;
  assign w_commit_ok   = addr_ok(w_commit_addr);
  assign w_commit_idx  = addr_idx(w_commit_addr);
  assign w_ar_ok       = addr_ok(s_axil_araddr);
  assign w_ar_idx      = addr_idx(s_axil_araddr);

  // Storage: cleared by reset, byte-lane writes on commit of an in-range address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit && w_commit_ok) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (w_commit_strb[b]) r_mem[w_commit_idx][8*b +: 8] <= w_commit_data[8*b +: 8];
      end
    end
  end

  // Write FSM: collects AW and W in either order, then holds B until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_commit) begin
      r_wstate  <= W_RESP;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_commit_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr  <= s_axil_awaddr;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_ADDR_HELD;
          end else if (w_w_hs) begin
            r_wdata   <= s_axil_wdata;
            r_wstrb   <= s_axil_wstrb;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_wstate  <= W_DATA_HELD;
          end else begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axil_bready) begin
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Read FSM: one outstanding read; data captured at the AR edge, before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata   <= w_ar_ok ? r_mem[w_ar_idx] : '0;
            r_rresp   <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_RESP;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axil_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_wready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rresp   = r_rresp;
  assign s_axil_rdata   = r_rdata;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Bench for axil_ram_slave: reset behaviour, vector table, multi-cycle corner
// sequences and randomized traffic against a word-array reference model.
module tb_axil_ram_slave;

  localparam int          DEPTH = 16;
  localparam int          SW    = 4;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [31:0] SPAN  = DEPTH * SW;

  logic        clk;
  logic        rst_n;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] mdl [DEPTH];

  axil_ram_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axil_awaddr (awaddr),
    .s_axil_awprot (awprot),
    .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata  (wdata),
    .s_axil_wstrb  (wstrb),
    .s_axil_wvalid (wvalid),
    .s_axil_wready (wready),
    .s_axil_bresp  (bresp),
    .s_axil_bvalid (bvalid),
    .s_axil_bready (bready),
    .s_axil_araddr (araddr),
    .s_axil_arprot (arprot),
    .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata  (rdata),
    .s_axil_rresp  (rresp),
    .s_axil_rvalid (rvalid),
    .s_axil_rready (rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got no handshake expected handshake within budget", name);
  endtask

  // Reference model: a flat word array with a window check.
  task automatic mdl_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
  endtask

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int w;
    if (a >= BASE && a < BASE + SPAN) begin
      w = int'((a - BASE) / SW);
      for (int b = 0; b < 4; b++) if (s[b]) mdl[w][8*b +: 8] = d[8*b +: 8];
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic mdl_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    if (a >= BASE && a < BASE + SPAN) begin
      d    = mdl[int'((a - BASE) / SW)];
      resp = 2'b00;
    end else begin
      d    = 32'h0;
      resp = 2'b10;
    end
  endtask

  // Called and returns at posedge+1. AW and W raised after independent delays.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp);
    int cyc;
    bit aw_done, w_done, hs_aw, hs_w, got;
    cyc = 0; aw_done = 0; w_done = 0; resp = 2'b11;
    while (!(aw_done && w_done)) begin
      if (!aw_done && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = a; end
      if (!w_done && cyc >= w_dly) begin wvalid = 1'b1; wdata = d; wstrb = s; end
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1;
      if (hs_aw) begin aw_done = 1; awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  wvalid  = 1'b0; end
      cyc++;
      if (cyc > 60) begin
        timeout_fail("aw_w_handshake");
        awvalid = 1'b0; wvalid = 1'b0;
        return;
      end
    end
    cyc = 0; got = 0;
    while (!got) begin
      if (cyc >= b_dly) bready = 1'b1;
      @(negedge clk);
      if (bvalid && bready) begin got = 1; resp = bresp; end
      @(posedge clk); #1;
      cyc++;
      if (got) bready = 1'b0;
      else if (cyc > 60) begin
        timeout_fail("b_handshake");
        bready = 1'b0;
        return;
      end
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                         output logic [31:0] d, output logic [1:0] resp);
    int cyc;
    bit hs, got;
    cyc = 0; hs = 0; d = 32'h0; resp = 2'b11;
    while (!hs) begin
      if (cyc >= ar_dly) begin arvalid = 1'b1; araddr = a; end
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) arvalid = 1'b0;
      cyc++;
      if (!hs && cyc > 60) begin
        timeout_fail("ar_handshake");
        arvalid = 1'b0;
        return;
      end
    end
    cyc = 0; got = 0;
    while (!got) begin
      if (cyc >= r_dly) rready = 1'b1;
      @(negedge clk);
      if (rvalid && rready) begin got = 1; d = rdata; resp = rresp; end
      @(posedge clk); #1;
      cyc++;
      if (got) rready = 1'b0;
      else if (cyc > 60) begin
        timeout_fail("r_handshake");
        rready = 1'b0;
        return;
      end
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  initial begin
    logic [1:0]  resp, mresp;
    logic [31:0] d, md;

    vt[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vt[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 2'b10, 32'h0};
    vt[3]  = '{1'b0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h0};
    vt[4]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h3, 2'b00, 32'h0};
    vt[5]  = '{1'b0, 32'h08, 32'h0,        4'h0, 2'b00, 32'h0000CCDD};
    vt[6]  = '{1'b1, 32'h08, 32'h11111111, 4'h0, 2'b00, 32'h0};
    vt[7]  = '{1'b0, 32'h09, 32'h0,        4'h0, 2'b00, 32'h0000CCDD};
    vt[8]  = '{1'b1, 32'h3C, 32'hFFFFFFFF, 4'h8, 2'b00, 32'h0};
    vt[9]  = '{1'b0, 32'h3F, 32'h0,        4'h0, 2'b00, 32'hFF000000};
    vt[10] = '{1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'h0};

    rst_n = 1'b0; awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    mdl_reset();

    // Reset state
    #12;
    check("reset_outputs", 32'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("readies_before_edge", 32'({awready, wready, arready}), 32'h0);
    @(posedge clk); #1;
    check("readies_first_edge", 32'({awready, wready, arready}), 32'h7);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      if (vt[i].wr) begin
        do_write(vt[i].addr, vt[i].data, vt[i].strb, 0, 0, 0, resp);
        mdl_write(vt[i].addr, vt[i].data, vt[i].strb, mresp);
        check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vt[i].exp_resp));
      end else begin
        do_read(vt[i].addr, 0, 0, d, resp);
        check($sformatf("vec%0d_rdata", i), d, vt[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vt[i].exp_resp));
      end
    end

    // W arrives alone and is held three cycles before AW
    wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'h5;
    @(negedge clk);
    check("wonly_wready", 32'(wready), 32'h1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("wheld_c%0d_ready_bvalid", c), 32'({wready, awready, bvalid}), 32'h2);
      @(posedge clk); #1;
    end
    awvalid = 1'b1; awaddr = 32'h4;
    @(negedge clk);
    check("wheld_awready", 32'(awready), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("wheld_b_latency", 32'({bvalid, bresp}), 32'h4);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    mdl_write(32'h4, 32'h11223344, 4'h5, mresp);
    do_read(32'h4, 0, 0, d, resp);
    check("wheld_merge_rdata", d, 32'hDE22BE44);

    // B and R held under back-pressure
    awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    mdl_write(32'h10, 32'hCAFEF00D, 4'hF, mresp);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bhold_c%0d", c), 32'({bvalid, bresp, awready, wready}), 32'h10);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("b_released", 32'(bvalid), 32'h0);
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 32'h10;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("rhold_c%0d_ctl", c), 32'({rvalid, rresp, arready}), 32'h8);
      check($sformatf("rhold_c%0d_data", c), rdata, 32'hCAFEF00D);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;

    // Read and write of the same word on the same edge
    awvalid = 1'b1; awaddr = 32'h20; wvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h20;
    @(negedge clk);
    check("same_edge_readies", 32'({awready, wready, arready}), 32'h7);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("same_edge_rdata_old", rdata, 32'h0);
    check("same_edge_valids", 32'({rvalid, bvalid, bresp}), 32'hC);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    mdl_write(32'h20, 32'hA5A5A5A5, 4'hF, mresp);
    do_read(32'h20, 0, 0, d, resp);
    check("same_edge_later_rdata", d, 32'hA5A5A5A5);

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a, wd;
      logic [3:0]  s;
      a = 32'($urandom_range(0, 18) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        s  = 4'($urandom_range(0, 15));
        mdl_write(a, wd, s, mresp);
        do_write(a, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp);
        check($sformatf("rnd%0d_bresp", i), 32'(resp), 32'(mresp));
      end else begin
        mdl_read(a, md, mresp);
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d, resp);
        check($sformatf("rnd%0d_rdata", i), d, md);
        check($sformatf("rnd%0d_rresp", i), 32'(resp), 32'(mresp));
      end
    end

    // Asynchronous reset while a write response is pending
    awvalid = 1'b1; awaddr = 32'h8; wvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("pre_reset_bvalid", 32'(bvalid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({bvalid, awready, wready, arready, rvalid, bresp}), 32'h0);
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_readies_low", 32'({awready, wready, arready}), 32'h0);
    @(posedge clk); #1;
    check("post_reset_readies_high", 32'({awready, wready, arready}), 32'h7);
    for (int w = 0; w < DEPTH; w++) begin
      mdl_read(32'(w * SW), md, mresp);
      do_read(32'(w * SW), 0, 0, d, resp);
      check($sformatf("post_reset_word%0d", w), d, md);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
